mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
Shares the single shared multiply unit between N_REQ requesters, for example the operand-digit accumulator (x10) and the final-result multiply path. The block arbitrates round-robin and issues one start pulse with latched operands. It waits for the multiplier's finish pulse and returns the product to the granted requester, with a watchdog timeout. It sits between the calculator controller and the multiply unit, replacing direct start/operand drive.

Parameters:
N_REQ, 2, number of requesters (2..8)
WIDTH, 16, operand/result width in bits
TIMEOUT, 64, max cycles spent in WAIT before error response (>=2)

Ports:
clk  input  1  system clock, rising edge
nRST  input  1  reset; one clock; reset is asynchronous and active-high
req  input  N_REQ  per-requester request level; requester holds it until its done pulse
op_a  input  N_REQ*WIDTH  flattened operand A; slice i belongs to requester i
op_b  input  N_REQ*WIDTH  flattened operand B; slice i belongs to requester i
gnt  output  N_REQ  one-hot grant; held from ISSUE through RESP
done  output  N_REQ  one-cycle completion pulse to the granted requester
result  output  WIDTH  product; valid in the cycle done is high, holds until the next RESP
err  output  1  high with done when the operation timed out
busy  output  1  high in any state other than IDLE
mult_start  output  1  one-cycle start pulse to the multiply unit
mult_in1  output  WIDTH  operand A to the multiply unit, stable from ISSUE until WAIT exits
mult_in2  output  WIDTH  operand B to the multiply unit
mult_out  input  WIDTH  multiply unit result, valid when mult_finish is high
mult_finish  input  1  multiply unit completion pulse

Behaviour:
- Reset (nRST high, async): state=IDLE; gnt, done, err, busy, mult_start = 0; result, mult_in1, mult_in2 = 0; rr pointer = N_REQ-1, so requester 0 has first priority; timer = 0.
- All outputs are registered. There are four states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req bit is set at a rising edge, pick the winner.
  - The winner is the first set bit searching from (ptr+1) mod N_REQ upward, wrapping around.
  - On that edge: gnt <= onehot(winner); mult_in1/mult_in2 <= winner's op_a/op_b slices; mult_start <= 1; go to ISSUE.
  - With no req, stay in IDLE.
- ISSUE: lasts exactly one cycle with mult_start=1. On the next edge: mult_start <= 0, timer <= 0, go to WAIT.
- WAIT:
  - If mult_finish: result <= mult_out, err <= 0, done <= gnt, go to RESP.
  - Else if timer == TIMEOUT-1: result <= 0, err <= 1, done <= gnt, go to RESP.
  - Else timer <= timer+1.
  - If finish and timeout fall in the same cycle, finish wins (err=0).
- RESP: lasts one cycle with done/err visible. On the next edge: done <= 0, err <= 0, gnt <= 0, ptr <= winner index, go to IDLE.
  - A requester still asserting req in IDLE is eligible again the following cycle, but loses to any other pending requester.
- Latency: req sampled in IDLE at edge k gives mult_start high in cycle k+1. If mult_finish is seen at edge m, done is high in cycle m+1. Minimum req-to-done is 3 cycles for a 1-cycle multiplier.
- mult_finish in IDLE, ISSUE or RESP is ignored (stray pulse); result is unchanged.
- req and operands are sampled only at the grant edge.
  - Later changes to op_a/op_b have no effect.
  - A req deasserted mid-operation does not abort it; done is still pulsed and the requester ignores it.
- Reset mid-operation: immediate return to reset values. A pending multiplier operation is abandoned and its later finish is ignored as stray.
- gnt is always zero or one-hot; done is a subset of gnt; at most one done bit is set at a time.
- The product is passed through unmodified (width WIDTH); no sign or overflow processing.

Test Plan:
- Single request: req=01, op_a[0]=12, op_b[0]=10, model finishes 5 cycles after start → exactly one mult_start, mult_in1=12, mult_in2=10, done=01 with result=120, err=0, busy falls the cycle after done.
- Round-robin: req=11 held continuously, requester 0 operands 3*10, requester 1 operands 7*-2 (0xFFF2) → grants alternate 01,10,01; results 30 then 0xFFF2*… passed through as mult_out; no requester granted twice while the other waits.
- Timeout: model never finishes, TIMEOUT=64 → done pulses exactly 64 cycles after ISSUE with err=1 and result=0; the next request proceeds normally.
- Finish on the timeout cycle: mult_finish with mult_out=0x0042 in the cycle timer==TIMEOUT-1 → err=0, result=0x0042.
- Stray finish and operand change: mult_finish pulsed in IDLE → no done, result unchanged; op_a changed from 5 to 9 during WAIT → product reflects 5.
- Reset mid-WAIT: assert nRST asynchronously between edges → gnt, busy, mult_start drop immediately; a late finish after release produces no done; the next req=10 is serviced normally.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that time-shares one multiply unit between N_REQ requesters.
// It latches the winner's operands, pulses start, then returns the product or a timeout error.
module mult_share_arbiter #(
    parameter int N_REQ   = 2,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     nRST,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   op_a,
    input  logic [N_REQ*WIDTH-1:0]   op_b,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic [WIDTH-1:0]         result,
    output logic                     err,
    output logic                     busy,
    output logic                     mult_start,
    output logic [WIDTH-1:0]         mult_in1,
    output logic [WIDTH-1:0]         mult_in2,
    input  logic [WIDTH-1:0]         mult_out,
    input  logic                     mult_finish
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               start_q, start_d;
    logic [WIDTH-1:0]   in1_q, in1_d;
    logic [WIDTH-1:0]   in2_q, in2_d;

    logic               found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;

    // Walk the requesters starting just after the last winner; the first set bit wins.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            cand = (cand == IDX_W'(N_REQ - 1)) ? '0 : cand + 1'b1;
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        timer_d  = timer_q;
        gnt_d    = gnt_q;
        done_d   = done_q;
        result_d = result_q;
        err_d    = err_q;
        start_d  = start_q;
        in1_d    = in1_q;
        in2_d    = in2_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    win_d          = win_idx;
                    in1_d          = op_a[win_idx*WIDTH +: WIDTH];
                    in2_d          = op_b[win_idx*WIDTH +: WIDTH];
                    start_d        = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                start_d = 1'b0;
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A finish arriving on the last allowed cycle still counts as success.
                if (mult_finish) begin
                    result_d = mult_out;
                    err_d    = 1'b0;
                    done_d   = gnt_q;
                    state_d  = RESP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    done_d   = gnt_q;
                    state_d  = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                done_d  = '0;
                err_d   = 1'b0;
                gnt_d   = '0;
                ptr_d   = win_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge nRST) begin
        if (nRST) begin
            state_q  <= IDLE;
            ptr_q    <= IDX_W'(N_REQ - 1);
            win_q    <= '0;
            timer_q  <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            in1_q    <= '0;
            in2_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            timer_q  <= timer_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign result     = result_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign mult_start = start_q;
    assign mult_in1   = in1_q;
    assign mult_in2   = in2_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter; the bench itself plays the multiply unit.
module tb_mult_share_arbiter;

    localparam int N_REQ   = 2;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 64;

    logic                   clk;
    logic                   nRST;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] op_a;
    logic [N_REQ*WIDTH-1:0] op_b;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic [WIDTH-1:0]       result;
    logic                   err;
    logic                   busy;
    logic                   mult_start;
    logic [WIDTH-1:0]       mult_in1;
    logic [WIDTH-1:0]       mult_in2;
    logic [WIDTH-1:0]       mult_out;
    logic                   mult_finish;

    int n_compared;
    int n_failed;

    mult_share_arbiter #(
        .N_REQ   (N_REQ),
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .nRST        (nRST),
        .req         (req),
        .op_a        (op_a),
        .op_b        (op_b),
        .gnt         (gnt),
        .done        (done),
        .result      (result),
        .err         (err),
        .busy        (busy),
        .mult_start  (mult_start),
        .mult_in1    (mult_in1),
        .mult_in2    (mult_in2),
        .mult_out    (mult_out),
        .mult_finish (mult_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_failed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one grant from the IDLE edge through RESP; finish arrives after 'delay' idle WAIT cycles.
    task automatic do_op(input string tag, input logic [N_REQ-1:0] exp_gnt,
                         input logic [WIDTH-1:0] exp_in1, input logic [WIDTH-1:0] exp_in2,
                         input int delay, input logic [WIDTH-1:0] prod,
                         input logic [WIDTH-1:0] exp_res, input logic exp_err);
        int extra_starts;
        extra_starts = 0;
        tick();
        check_output({tag, "_start"}, 32'(mult_start), 32'd1);
        check_output({tag, "_gnt"},   32'(gnt),        32'(exp_gnt));
        check_output({tag, "_in1"},   32'(mult_in1),   32'(exp_in1));
        check_output({tag, "_in2"},   32'(mult_in2),   32'(exp_in2));
        check_output({tag, "_busy"},  32'(busy),       32'd1);
        tick();
        check_output({tag, "_start_drop"}, 32'(mult_start), 32'd0);
        for (int d = 0; d < delay; d++) begin
            tick();
            if (mult_start) extra_starts++;
        end
        check_output({tag, "_extra_start"}, 32'(extra_starts), 32'd0);
        check_output({tag, "_early_done"},  32'(done),         32'd0);
        mult_finish = 1'b1;
        mult_out    = prod;
        tick();
        mult_finish = 1'b0;
        mult_out    = '0;
        check_output({tag, "_done"},   32'(done),   32'(exp_gnt));
        check_output({tag, "_result"}, 32'(result), 32'(exp_res));
        check_output({tag, "_err"},    32'(err),    32'(exp_err));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        n_compared  = 0;
        n_failed    = 0;
        nRST        = 1'b1;
        req         = '0;
        op_a        = '0;
        op_b        = '0;
        mult_out    = '0;
        mult_finish = 1'b0;

        tick();
        tick();
        check_output("rst_gnt",    32'(gnt),        32'd0);
        check_output("rst_done",   32'(done),       32'd0);
        check_output("rst_err",    32'(err),        32'd0);
        check_output("rst_busy",   32'(busy),       32'd0);
        check_output("rst_start",  32'(mult_start), 32'd0);
        check_output("rst_result", 32'(result),     32'd0);
        check_output("rst_in1",    32'(mult_in1),   32'd0);
        check_output("rst_in2",    32'(mult_in2),   32'd0);
        nRST = 1'b0;
        tick();

        // Single request from requester 0: 12 * 10.
        req = 2'b01;
        op_a[0*WIDTH +: WIDTH] = 16'd12;
        op_b[0*WIDTH +: WIDTH] = 16'd10;
        do_op("single", 2'b01, 16'd12, 16'd10, 3, 16'd120, 16'd120, 1'b0);
        req = 2'b00;
        tick();
        check_output("single_busy_fall", 32'(busy),   32'd0);
        check_output("single_done_fall", 32'(done),   32'd0);
        check_output("single_gnt_fall",  32'(gnt),    32'd0);
        check_output("single_hold",      32'(result), 32'd120);

        // Both requesting; requester 0 just won, so requester 1 goes first.
        req = 2'b11;
        op_a[0*WIDTH +: WIDTH] = 16'd3;
        op_b[0*WIDTH +: WIDTH] = 16'd10;
        op_a[1*WIDTH +: WIDTH] = 16'd7;
        op_b[1*WIDTH +: WIDTH] = 16'hFFFE;
        do_op("rr1", 2'b10, 16'd7, 16'hFFFE, 1, 16'hFFF2, 16'hFFF2, 1'b0);
        tick();
        check_output("rr1_idle_gnt", 32'(gnt), 32'd0);
        do_op("rr2", 2'b01, 16'd3, 16'd10, 2, 16'd30, 16'd30, 1'b0);
        tick();
        do_op("rr3", 2'b10, 16'd7, 16'hFFFE, 0, 16'hFFF2, 16'hFFF2, 1'b0);
        req = 2'b00;
        tick();

        // Timeout: the multiplier never answers.
        req = 2'b01;
        op_a[0*WIDTH +: WIDTH] = 16'd1;
        op_b[0*WIDTH +: WIDTH] = 16'd1;
        tick();
        check_output("to_start", 32'(mult_start), 32'd1);
        tick();
        cycles = 0;
        while (done == '0 && cycles < 200) begin
            tick();
            cycles++;
        end
        check_output("to_cycles", 32'(cycles), 32'd64);
        check_output("to_done",   32'(done),   32'b01);
        check_output("to_err",    32'(err),    32'd1);
        check_output("to_result", 32'(result), 32'd0);
        req = 2'b00;
        tick();
        check_output("to_err_clear", 32'(err),  32'd0);
        check_output("to_idle",      32'(busy), 32'd0);

        req = 2'b10;
        op_a[1*WIDTH +: WIDTH] = 16'd4;
        op_b[1*WIDTH +: WIDTH] = 16'd5;
        do_op("after_to", 2'b10, 16'd4, 16'd5, 1, 16'd20, 16'd20, 1'b0);
        req = 2'b00;
        tick();

        // Finish arriving exactly on the timeout cycle must win.
        req = 2'b01;
        op_a[0*WIDTH +: WIDTH] = 16'h0011;
        op_b[0*WIDTH +: WIDTH] = 16'h0022;
        do_op("edge_to", 2'b01, 16'h0011, 16'h0022, TIMEOUT - 1, 16'h0042, 16'h0042, 1'b0);
        req = 2'b00;
        tick();

        // Stray finish in IDLE.
        mult_finish = 1'b1;
        mult_out    = 16'h1234;
        tick();
        mult_finish = 1'b0;
        mult_out    = '0;
        check_output("stray_done",   32'(done),   32'd0);
        check_output("stray_result", 32'(result), 32'h0042);
        check_output("stray_busy",   32'(busy),   32'd0);

        // Operand change during WAIT has no effect.
        req = 2'b10;
        op_a[1*WIDTH +: WIDTH] = 16'd5;
        op_b[1*WIDTH +: WIDTH] = 16'd3;
        tick();
        check_output("opchg_gnt", 32'(gnt),      32'b10);
        check_output("opchg_in1", 32'(mult_in1), 32'd5);
        op_a[1*WIDTH +: WIDTH] = 16'd9;
        tick();
        tick();
        check_output("opchg_in1_wait", 32'(mult_in1), 32'd5);
        mult_finish = 1'b1;
        mult_out    = 16'd15;
        tick();
        mult_finish = 1'b0;
        mult_out    = '0;
        check_output("opchg_done",   32'(done),   32'b10);
        check_output("opchg_result", 32'(result), 32'd15);
        req = 2'b00;
        tick();

        // Asynchronous reset in the middle of WAIT.
        req = 2'b01;
        op_a[0*WIDTH +: WIDTH] = 16'd2;
        op_b[0*WIDTH +: WIDTH] = 16'd2;
        tick();
        tick();
        tick();
        check_output("rstw_busy_pre", 32'(busy), 32'd1);
        #2;
        nRST = 1'b1;
        #1;
        check_output("rstw_gnt",    32'(gnt),        32'd0);
        check_output("rstw_busy",   32'(busy),       32'd0);
        check_output("rstw_start",  32'(mult_start), 32'd0);
        check_output("rstw_result", 32'(result),     32'd0);
        req = 2'b00;
        #2;
        nRST = 1'b0;
        tick();
        mult_finish = 1'b1;
        mult_out    = 16'h0099;
        tick();
        mult_finish = 1'b0;
        mult_out    = '0;
        check_output("late_done",   32'(done),   32'd0);
        check_output("late_result", 32'(result), 32'd0);
        check_output("late_busy",   32'(busy),   32'd0);

        req = 2'b10;
        op_a[1*WIDTH +: WIDTH] = 16'd6;
        op_b[1*WIDTH +: WIDTH] = 16'd7;
        do_op("post_rst", 2'b10, 16'd6, 16'd7, 2, 16'd42, 16'd42, 1'b0);
        req = 2'b00;
        tick();
        check_output("final_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
